// File: rtl/output_port_fifo.sv
// rtl/output_port_fifo.sv - output port FIFO between the control unit and an external device
module output_port_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     OutputWrite,
    input  logic [WIDTH-1:0]         OutData,
    input  logic                     OutReady,
    input  logic                     OverflowClear,
    output logic                     OutValid,
    output logic [WIDTH-1:0]         OutPort,
    output logic [WIDTH-1:0]         LastOut,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Full,
    output logic                     Empty,
    output logic                     Overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_last_out;
    logic             r_overflow;

    logic             w_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [WIDTH-1:0] w_head;

    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = w_valid && OutReady;
    // A full FIFO still accepts a word when a pop frees a slot in the same cycle.
    assign w_push  = OutputWrite && (!w_full || w_pop);
    assign w_drop  = OutputWrite && w_full && !w_pop;
    // Gate the head so stale storage contents never reach the device.
    assign w_head  = w_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= OutData;
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_last_out <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + AW'(1);
                r_last_out <= w_head;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            // A drop in the same cycle as a clear wins, so no drop goes unreported.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (OverflowClear) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign OutValid = w_valid;
    assign OutPort  = w_head;
    assign LastOut  = r_last_out;
    assign Count    = r_count;
    assign Full     = w_full;
    assign Empty    = !w_valid;
    assign Overflow = r_overflow;

endmodule

// File: tb/tb_output_port_fifo.sv
// tb/tb_output_port_fifo.sv - scoreboard testbench for output_port_fifo
module tb_output_port_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             CLK;
    logic             Reset;
    logic             OutputWrite;
    logic [WIDTH-1:0] OutData;
    logic             OutReady;
    logic             OverflowClear;
    logic             OutValid;
    logic [WIDTH-1:0] OutPort;
    logic [WIDTH-1:0] LastOut;
    logic [2:0]       Count;
    logic             Full;
    logic             Empty;
    logic             Overflow;

    int n_checks;
    int n_fails;
    logic [WIDTH-1:0] sb [$];

    output_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .Reset(Reset), .OutputWrite(OutputWrite), .OutData(OutData),
        .OutReady(OutReady), .OverflowClear(OverflowClear), .OutValid(OutValid),
        .OutPort(OutPort), .LastOut(LastOut), .Count(Count), .Full(Full),
        .Empty(Empty), .Overflow(Overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every accepted word is checked against the scoreboard head.
    always @(negedge CLK) begin
        if (Reset) begin
            chk("full_and_empty", 32'(Full && Empty), 32'd0);
            if (OutValid && OutReady) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pop", 32'(OutPort), 32'hFFFF_FFFF);
                end else begin
                    chk("pop_data", 32'(OutPort), 32'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        Reset = 1'b0; OutputWrite = 1'b0; OutData = '0; OutReady = 1'b0; OverflowClear = 1'b0;
        step(); step();
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_empty", 32'(Empty), 32'd1);
        chk("rst_full", 32'(Full), 32'd0);
        chk("rst_valid", 32'(OutValid), 32'd0);
        chk("rst_outport", 32'(OutPort), 32'd0);
        chk("rst_lastout", 32'(LastOut), 32'd0);
        chk("rst_overflow", 32'(Overflow), 32'd0);
        Reset = 1'b1;
        step();

        // Single word
        OutputWrite = 1'b1; OutData = 16'h00A5; sb.push_back(16'h00A5);
        step();
        OutputWrite = 1'b0;
        chk("single_valid", 32'(OutValid), 32'd1);
        chk("single_port", 32'(OutPort), 32'h00A5);
        chk("single_count", 32'(Count), 32'd1);
        OutReady = 1'b1;
        step();
        OutReady = 1'b0;
        chk("single_valid_after", 32'(OutValid), 32'd0);
        chk("single_lastout", 32'(LastOut), 32'h00A5);

        // Fill and overflow
        for (int i = 1; i <= 5; i++) begin
            OutputWrite = 1'b1; OutData = 16'(i);
            if (i <= 4) sb.push_back(16'(i));
            step();
            if (i == 4) begin
                chk("fill_full", 32'(Full), 32'd1);
                chk("fill_overflow_pre", 32'(Overflow), 32'd0);
            end
        end
        OutputWrite = 1'b0;
        chk("fill_overflow", 32'(Overflow), 32'd1);
        chk("fill_count", 32'(Count), 32'd4);
        OverflowClear = 1'b1;
        step();
        OverflowClear = 1'b0;
        chk("ovf_cleared", 32'(Overflow), 32'd0);

        // Full with simultaneous push and pop
        OutputWrite = 1'b1; OutData = 16'h0009; OutReady = 1'b1; sb.push_back(16'h0009);
        step();
        OutputWrite = 1'b0;
        chk("simul_count", 32'(Count), 32'd4);
        chk("simul_overflow", 32'(Overflow), 32'd0);
        repeat (4) step();
        OutReady = 1'b0;
        chk("simul_empty", 32'(Empty), 32'd1);
        chk("simul_lastout", 32'(LastOut), 32'h0009);

        // Streaming through pointer wrap
        OutReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            OutputWrite = 1'b1; OutData = 16'(16'h0100 + i); sb.push_back(16'(16'h0100 + i));
            step();
            chk("stream_count_le1", 32'(Count <= 3'd1), 32'd1);
        end
        OutputWrite = 1'b0;
        step();
        chk("stream_empty", 32'(Empty), 32'd1);
        chk("stream_overflow", 32'(Overflow), 32'd0);
        step();
        chk("empty_lastout_hold", 32'(LastOut), 32'h0109);
        chk("empty_ready_count", 32'(Count), 32'd0);
        OutReady = 1'b0;

        // Reset mid-operation
        for (int i = 0; i < 5; i++) begin
            OutputWrite = 1'b1; OutData = 16'(16'h0021 + i);
            if (i < 4) sb.push_back(16'(16'h0021 + i));
            step();
        end
        OutputWrite = 1'b0;
        OutReady = 1'b1;
        step();
        OutReady = 1'b0;
        chk("pre_rst_count", 32'(Count), 32'd3);
        chk("pre_rst_overflow", 32'(Overflow), 32'd1);
        Reset = 1'b0; OutputWrite = 1'b1; OutData = 16'hDEAD;
        step();
        sb.delete();
        chk("midrst_count", 32'(Count), 32'd0);
        chk("midrst_valid", 32'(OutValid), 32'd0);
        chk("midrst_overflow", 32'(Overflow), 32'd0);
        chk("midrst_lastout", 32'(LastOut), 32'd0);
        chk("midrst_outport", 32'(OutPort), 32'd0);

        // First cycle after reset release
        Reset = 1'b1; OutputWrite = 1'b1; OutData = 16'h0077; sb.push_back(16'h0077);
        step();
        OutputWrite = 1'b0;
        chk("post_rst_count", 32'(Count), 32'd1);
        chk("post_rst_port", 32'(OutPort), 32'h0077);

        // Overflow clear race
        for (int i = 0; i < 3; i++) begin
            OutputWrite = 1'b1; OutData = 16'(16'h0031 + i); sb.push_back(16'(16'h0031 + i));
            step();
        end
        OutData = 16'h003E;
        step();
        chk("race_pre_overflow", 32'(Overflow), 32'd1);
        OutData = 16'h003F; OverflowClear = 1'b1;
        step();
        OutputWrite = 1'b0;
        chk("race_overflow_kept", 32'(Overflow), 32'd1);
        step();
        OverflowClear = 1'b0;
        chk("race_overflow_clr", 32'(Overflow), 32'd0);
        chk("race_count", 32'(Count), 32'd4);
        OutReady = 1'b1;
        repeat (4) step();
        OutReady = 1'b0;
        chk("final_empty", 32'(Empty), 32'd1);
        chk("final_lastout", 32'(LastOut), 32'h0033);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/output_port_fifo.md
OUTPUT_PORT_FIFO -- requirements
Module: output_port_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data word width.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the FIFO entry count; DEPTH SHALL be a power of two, 2 or greater.
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Reset  input  1  reset, synchronous and active-low: the block is reset on a CLK rising edge while Reset=0.
REQ-005 OutputWrite  input  1  control-unit strobe, one cycle per executed "out" instruction.
REQ-006 OutData  input  WIDTH  register-file value to emit; sampled when OutputWrite=1.
REQ-007 OutReady  input  1  external device is ready to take OutPort this cycle.
REQ-008 OverflowClear  input  1  clears the sticky Overflow flag.
REQ-009 OutValid  output  1  OutPort holds a valid, unconsumed word.
REQ-010 OutPort  output  WIDTH  head-of-FIFO word presented to the device.
REQ-011 LastOut  output  WIDTH  last word accepted by the device, for display.
REQ-012 Count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 Full  output  1  Count==DEPTH.
REQ-014 Empty  output  1  Count==0.
REQ-015 Overflow  output  1  sticky flag: a word was dropped.

Function
REQ-016 push SHALL be defined as OutputWrite=1 and (Full=0 or pop in the same cycle); pop SHALL be defined as OutValid=1 and OutReady=1.
REQ-017 On push, OutData SHALL be written at the write pointer, and the write pointer SHALL advance modulo DEPTH.
REQ-018 On pop, the read pointer SHALL advance modulo DEPTH, and LastOut SHALL load the popped OutPort value.
REQ-019 Count SHALL increment on push only, decrement on pop only, and hold when both or neither occur.
REQ-020 OutValid SHALL equal (Count!=0), and OutPort SHALL equal the entry at the read pointer; both SHALL be derived from registered state only.
REQ-021 Latency SHALL be as follows: a word pushed in cycle N SHALL appear on OutPort with OutValid=1 in cycle N+1 if the FIFO was empty; no combinational path SHALL exist from OutData to OutPort.
REQ-022 While OutValid=1 and OutReady=0, OutPort and OutValid SHALL remain stable.
REQ-023 Full with simultaneous push and pop: both SHALL be accepted, Count SHALL stay DEPTH, and the new word SHALL queue behind the remaining entries.
REQ-024 Full with OutputWrite=1 and no pop: the word SHALL be dropped, the pointers and Count SHALL be unchanged, and Overflow SHALL be set next cycle.
REQ-025 Overflow SHALL stay set until a cycle with OverflowClear=1; if a new drop coincides with OverflowClear, Overflow SHALL remain 1.
REQ-026 Empty: pop cannot occur; OutReady SHALL be ignored, and LastOut SHALL hold.
REQ-027 Pointer wrap: after DEPTH pushes and DEPTH pops, word order SHALL be preserved across the wrap with no lost or duplicated entry.
REQ-028 Full and Empty SHALL never both be 1.

Reset
REQ-029 When reset (Reset=0 at a CLK edge), the pointers SHALL be 0, Count=0, Empty=1, Full=0, OutValid=0, OutPort=0, LastOut=0, and Overflow=0; FIFO storage contents SHALL be don't-care but SHALL not be visible on OutPort.
REQ-030 Reset SHALL take priority over OutputWrite, OutReady, and OverflowClear in the same cycle; words in flight mid-operation SHALL be discarded.
REQ-031 In the first cycle after Reset returns to 1, a push SHALL be accepted normally.

Verification
REQ-032 Single word: with OutReady=0, OutputWrite=1 and OutData=0x00A5 for one cycle -> next cycle OutValid=1, OutPort=0x00A5, Count=1; raise OutReady -> next cycle OutValid=0, LastOut=0x00A5.
REQ-033 Fill and overflow: with OutReady=0, push 0x0001..0x0005 on consecutive cycles -> Full=1 after the 4th push, the 5th is dropped, Overflow=1; drain -> 1, 2, 3, 4 in order.
REQ-034 Full simultaneous: with the FIFO full of 1..4, assert OutputWrite=1 with 0x0009 and OutReady=1 -> Count stays 4, Overflow=0; drained order is 2, 3, 4, 9.
REQ-035 Wrap: stream 10 words with OutReady=1 and pushes every cycle -> the device receives all 10 in order, Count never exceeds 1, Overflow=0.
REQ-036 Reset mid-operation: with 3 words queued and Overflow=1, hold Reset=0 for one edge while OutputWrite=1 -> Count=0, OutValid=0, Overflow=0, LastOut=0.
REQ-037 Overflow clear race: with Overflow=1, assert OverflowClear together with a dropped push -> Overflow=1; OverflowClear alone next cycle -> Overflow=0.
